btn_action_scheduler: RTL and testbench

- Converts the four raw Tetris push-buttons into single-cycle game action pulses.
- Button map: btn[0]=left, btn[1]=right, btn[2]=rotate, btn[3]=down.
- Per-button chain: 2-flop synchronizer, debounce counter, auto-repeat state machine.
- A round-robin arbiter issues at most one action per cycle to the game logic, gated by its ready signal.
- Sits between the board buttons and the game-state FSM.

---
 rtl/btn_action_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_btn_action_scheduler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/btn_action_scheduler.sv
// Debounces the four Tetris buttons, generates auto-repeat requests and issues at most one
// one-hot game action per cycle via a round-robin arbiter. Optional macro: BTN_OPPOSE_LOCK_EN.
module btn_action_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DAS_DELAY       = 10000000,
    parameter int unsigned DAS_RATE        = 2500000,
    parameter logic [3:0]  REPEAT_MASK     = 4'b1011,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       game_ready,
    output logic [3:0] pressed,
    output logic [3:0] action,
    output logic       action_valid
);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat, StHold} rep_state_e;

    localparam logic [CNT_W-1:0] DbLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DelayLast = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] RateLast  = CNT_W'(DAS_RATE - 1);

    // Synchronizer
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce
    logic [3:0]       pressed_q;
    logic [3:0]       pressed_d;
    logic [CNT_W-1:0] dcnt_q [4];
    logic [CNT_W-1:0] dcnt_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dcnt_d[i]    = '0;
            pressed_d[i] = pressed_q[i];
            if (sync2_q[i] != pressed_q[i]) begin
                if (dcnt_q[i] == DbLast) begin
                    pressed_d[i] = ~pressed_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pressed_q <= '0;
            for (int i = 0; i < 4; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            pressed_q <= pressed_d;
            for (int i = 0; i < 4; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    // Auto-repeat
    logic oppose_lock;

`ifdef BTN_OPPOSE_LOCK_EN
    assign oppose_lock = pressed_q[0] & pressed_q[1];
`else
    assign oppose_lock = 1'b0;
`endif

    rep_state_e       rep_q  [4];
    rep_state_e       rep_d  [4];
    logic [CNT_W-1:0] rcnt_q [4];
    logic [CNT_W-1:0] rcnt_d [4];
    logic [3:0]       req;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rep_d[i]  = rep_q[i];
            rcnt_d[i] = rcnt_q[i];
            req[i]    = 1'b0;
            if (!pressed_q[i]) begin
                rep_d[i]  = StIdle;
                rcnt_d[i] = '0;
            end else begin
                case (rep_q[i])
                    StIdle: begin
                        req[i]    = 1'b1;
                        rcnt_d[i] = '0;
                        rep_d[i]  = REPEAT_MASK[i] ? StDelay : StHold;
                    end
                    StDelay: begin
                        if (oppose_lock && (i < 2)) begin
                            rcnt_d[i] = '0;
                        end else if (rcnt_q[i] == DelayLast) begin
                            req[i]    = 1'b1;
                            rcnt_d[i] = '0;
                            rep_d[i]  = StRepeat;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                    StRepeat: begin
                        // Opposing lock restarts the full initial delay once released
                        if (oppose_lock && (i < 2)) begin
                            rcnt_d[i] = '0;
                            rep_d[i]  = StDelay;
                        end else if (rcnt_q[i] == RateLast) begin
                            req[i]    = 1'b1;
                            rcnt_d[i] = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                    StHold: begin
                        rcnt_d[i] = '0;
                    end
                    default: begin
                        rep_d[i]  = StIdle;
                        rcnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rep_q[i]  <= StIdle;
                rcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                rep_q[i]  <= rep_d[i];
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end

    // Pending requests and round-robin arbiter
    logic [3:0] pending_q;
    logic [3:0] pending_d;
    logic [3:0] grant;
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] win_idx;
    logic [1:0] probe;
    logic       found;
    logic [3:0] action_q;
    logic [3:0] action_d;
    logic       valid_q;
    logic       valid_d;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        probe   = '0;
        for (int k = 0; k < 4; k++) begin
            probe = ptr_q + 2'(k);
            if (!found && pending_q[probe]) begin
                found   = 1'b1;
                win_idx = probe;
            end
        end

        grant    = '0;
        action_d = '0;
        valid_d  = 1'b0;
        ptr_d    = ptr_q;
        if (game_ready && found) begin
            grant    = 4'b0001 << win_idx;
            action_d = grant;
            valid_d  = 1'b1;
            ptr_d    = win_idx + 2'd1;
        end

        // A new request in the grant cycle must survive the clear
        pending_d = (pending_q & ~grant) | req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            ptr_q     <= '0;
            action_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            action_q  <= action_d;
            valid_q   <= valid_d;
        end
    end

    assign pressed      = pressed_q;
    assign action       = action_q;
    assign action_valid = valid_q;

endmodule

// File: tb/tb_btn_action_scheduler.sv
// Directed bench for btn_action_scheduler with short debounce/repeat parameters;
// expected values are hand-derived cycle numbers relative to each stimulus edge.
module tb_btn_action_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       game_ready;
    logic [3:0] pressed;
    logic [3:0] action;
    logic       action_valid;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    btn_action_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .DAS_DELAY      (10),
        .DAS_RATE       (3),
        .REPEAT_MASK    (4'b1011),
        .CNT_W          (24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .game_ready  (game_ready),
        .pressed     (pressed),
        .action      (action),
        .action_valid(action_valid)
    );

    task automatic chk(input string tag, input int cyc, input logic [3:0] obs,
                       input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input int c, input logic [3:0] ep,
                               input logic [3:0] ea, input logic ev);
        chk({tag, ".pressed"}, c, pressed, ep);
        chk({tag, ".action"}, c, action, ea);
        chk({tag, ".valid"}, c, {3'b000, action_valid}, {3'b000, ev});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        btn        = 4'b0000;
        game_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] ep;
        logic [3:0] ea;
        logic       ev;

        // Reset with all buttons held: outputs stay quiet, and after release the
        // debounce still has to run before anything appears.
        rst        = 1'b1;
        btn        = 4'b1111;
        game_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_cycle("rst_hold", c, 4'b0000, 4'b0000, 1'b0);
        end
        rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check_cycle("post_rst", c, 4'b0000, 4'b0000, 1'b0);
        end

        // Glitches of 2 and 3 cycles (shorter than debounce) are ignored
        for (int w = 2; w <= 3; w++) begin
            do_reset();
            btn = 4'b0001;
            for (int c = 1; c <= 15; c++) begin
                tick();
                check_cycle((w == 2) ? "glitch2" : "glitch3", c, 4'b0000, 4'b0000, 1'b0);
                if (c == w) btn = 4'b0000;
            end
        end

        // Left held 40 cycles: press at 6, action at 8, first repeat at 18, then every 3
        do_reset();
        btn = 4'b0001;
        for (int c = 1; c <= 60; c++) begin
            tick();
            ep = (c >= 6 && c < 46) ? 4'b0001 : 4'b0000;
            ev = (c == 8) || (c >= 18 && c <= 45 && ((c - 18) % 3) == 0);
            ea = ev ? 4'b0001 : 4'b0000;
            check_cycle("left_hold", c, ep, ea, ev);
            if (c == 40) btn = 4'b0000;
        end

        // Rotate held 40 cycles: one action only
        do_reset();
        btn = 4'b0100;
        for (int c = 1; c <= 60; c++) begin
            tick();
            ep = (c >= 6 && c < 46) ? 4'b0100 : 4'b0000;
            ev = (c == 8);
            ea = ev ? 4'b0100 : 4'b0000;
            check_cycle("rot_hold", c, ep, ea, ev);
            if (c == 40) btn = 4'b0000;
        end

        // All four at once: round-robin from ptr 0, pointer wraps back to 0 so the
        // repeats (rotate excluded) come out in order 0,1,3.
        do_reset();
        btn = 4'b1111;
        for (int c = 1; c <= 20; c++) begin
            tick();
            ep = (c >= 6) ? 4'b1111 : 4'b0000;
            case (c)
                8:       ea = 4'b0001;
                9:       ea = 4'b0010;
                10:      ea = 4'b0100;
                11:      ea = 4'b1000;
                18:      ea = 4'b0001;
                19:      ea = 4'b0010;
                20:      ea = 4'b1000;
                default: ea = 4'b0000;
            endcase
            ev = (ea != 4'b0000);
            check_cycle("all_rr", c, ep, ea, ev);
        end

        // Right tapped while game not ready: request is held until ready returns
        do_reset();
        game_ready = 1'b0;
        btn        = 4'b0010;
        for (int c = 1; c <= 115; c++) begin
            tick();
            ep = (c >= 6 && c < 14) ? 4'b0010 : 4'b0000;
            ev = (c == 109);
            ea = ev ? 4'b0010 : 4'b0000;
            check_cycle("ready_hold", c, ep, ea, ev);
            if (c == 8) btn = 4'b0000;
            if (c == 108) game_ready = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
